// File: rtl/alu_sequencer.sv
// Multi-cycle control sequencer for the 8-bit CPU: decodes instructions, drives the
// ALU from a small register file, writes results back and streams register values out.
module alu_sequencer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREG   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted,
    output logic [7:0]        retire_cnt
);

    localparam int unsigned INSTR_W = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned IDX_W   = 2;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_OUT  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        OUTP,
        HALT
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  regs [NREG];

    logic [1:0]         op;
    logic [IDX_W-1:0]   rs;
    logic [IDX_W-1:0]   rt;
    logic [IDX_W-1:0]   rd;
    logic [DATA_W-1:0]  imm_sext;
    logic [IDX_W-1:0]   wr_idx;
    logic               wr_en;
    logic               retire;

    assign op       = ir[7:6];
    assign rs       = ir[5:4];
    assign rt       = ir[3:2];
    assign rd       = ir[1:0];
    assign imm_sext = {{(DATA_W-2){ir[1]}}, ir[1:0]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus write-back and retire strobes
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        retire  = 1'b0;
        wr_idx  = (op == OP_ADD) ? rd : rt;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                case (op)
                    OP_ADD, OP_ADDI: state_d = EXEC;
                    OP_OUT:          state_d = OUTP;
                    default: begin
                        state_d = HALT;
                        retire  = 1'b1;
                    end
                endcase
            end
            EXEC: begin
                state_d = IDLE;
                wr_en   = 1'b1;
                retire  = 1'b1;
            end
            OUTP: begin
                if (out_ready) begin
                    state_d = IDLE;
                    retire  = 1'b1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; status flags track the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            ir          <= '0;
            instr_ready <= 1'b1;
            alu_op      <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            halted      <= 1'b0;
            retire_cnt  <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            instr_ready <= (state_d == IDLE);
            alu_op      <= (state_d == EXEC);
            out_valid   <= (state_d == OUTP);
            halted      <= (state_d == HALT);

            if (state_q == IDLE && instr_valid) begin
                ir <= instr;
            end

            if (state_q == DECODE) begin
                if (state_d == EXEC) begin
                    alu_a <= regs[rs];
                    alu_b <= (op == OP_ADDI) ? imm_sext : regs[rt];
                end
                if (state_d == OUTP) begin
                    out_data <= regs[rs];
                end
            end

            if (wr_en) begin
                regs[wr_idx] <= alu_result;
            end

            if (retire) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: expected ALU operand pairs and output words are
// queued by the stimulus thread and checked by a negedge monitor.
module tb_alu_sequencer;

    logic       clk;
    logic       reset;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic       alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       halted;
    logic [7:0] retire_cnt;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] aluq [$];
    logic [7:0]  outq [$];
    logic [15:0] mon_alu;

    alu_sequencer #(.DATA_W(8), .NREG(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .halted     (halted),
        .retire_cnt (retire_cnt)
    );

    // Combinational ALU the sequencer drives
    assign alu_result = alu_op ? 8'(alu_a + alu_b) : 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every ALU cycle consumes one expected operand pair; every output
    // cycle is compared against the queue head and the head pops on handshake.
    always @(negedge clk) begin
        if (alu_op === 1'b1) begin
            if (aluq.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL alu_unexpected: got a=%0h b=%0h expected no ALU op (t=%0t)",
                         alu_a, alu_b, $time);
            end else begin
                mon_alu = aluq.pop_front();
                chk("alu_a", 32'(alu_a), 32'(mon_alu[15:8]));
                chk("alu_b", 32'(alu_b), 32'(mon_alu[7:0]));
            end
        end
        if (reset === 1'b0 && out_valid === 1'b1) begin
            if (outq.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL out_unexpected: got %0h expected no output (t=%0t)", out_data, $time);
            end else begin
                chk("out_data", 32'(out_data), 32'(outq[0]));
                if (out_ready) begin
                    void'(outq.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        instr_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (instr_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("ready_wait", 32'(instr_ready), 32'd1);
    endtask

    task automatic issue(input logic [7:0] i);
        wait_ready();
        instr       = i;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        instr       = 8'($urandom);
    endtask

    task automatic run(input logic [7:0] i);
        issue(i);
        wait_ready();
    endtask

    task automatic exp_alu(input logic [7:0] a, input logic [7:0] b);
        aluq.push_back({a, b});
    endtask

    task automatic outreg(input logic [1:0] idx, input logic [7:0] v);
        logic [7:0] code;
        code = {2'b10, idx, 4'b0000};
        outq.push_back(v);
        run(code);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int last;
        reset       = 1'b1;
        instr       = 8'h00;
        instr_valid = 1'b0;
        out_ready   = 1'b1;
        do_reset();

        chk("rst_instr_ready", 32'(instr_ready), 32'd1);
        chk("rst_out_valid",   32'(out_valid),   32'd0);
        chk("rst_out_data",    32'(out_data),    32'd0);
        chk("rst_halted",      32'(halted),      32'd0);
        chk("rst_retire",      32'(retire_cnt),  32'd0);
        chk("rst_alu_op",      32'(alu_op),      32'd0);
        chk("rst_alu_a",       32'(alu_a),       32'd0);
        chk("rst_alu_b",       32'(alu_b),       32'd0);

        // ADDI r0+1 -> r1 with exact cycle-by-cycle latency
        exp_alu(8'h00, 8'h01);
        instr       = 8'h45;
        instr_valid = 1'b1;
        tick();
        instr       = 8'hFF;
        instr_valid = 1'b0;
        chk("t1_instr_ready", 32'(instr_ready), 32'd0);
        chk("t1_alu_op",      32'(alu_op),      32'd0);
        tick();
        chk("t2_alu_op", 32'(alu_op), 32'd1);
        chk("t2_alu_a",  32'(alu_a),  32'h00);
        chk("t2_alu_b",  32'(alu_b),  32'h01);
        tick();
        chk("t3_instr_ready", 32'(instr_ready), 32'd1);
        chk("t3_alu_op",      32'(alu_op),      32'd0);
        chk("t3_retire",      32'(retire_cnt),  32'd1);

        // ADDI r1-2 -> r1 gives 0xFF; ADD r1+r1 -> r2 wraps to 0xFE
        exp_alu(8'h01, 8'hFE);
        run(8'h56);
        exp_alu(8'hFF, 8'hFF);
        run(8'h16);

        // OUT r2 with a 5-cycle consumer stall
        out_ready = 1'b0;
        outq.push_back(8'hFE);
        issue(8'hA0);
        chk("outp_t1_valid", 32'(out_valid), 32'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("outp_hold_valid", 32'(out_valid),   32'd1);
            chk("outp_hold_data",  32'(out_data),    32'hFE);
            chk("outp_hold_ready", 32'(instr_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        chk("outp_last_valid", 32'(out_valid), 32'd1);
        tick();
        chk("outp_done_valid", 32'(out_valid),   32'd0);
        chk("outp_done_ready", 32'(instr_ready), 32'd1);
        chk("outp_retire",     32'(retire_cnt),  32'd4);

        // Stream ADDI r0+1 -> r0 four times with instr_valid held high
        do_reset();
        chk("rst2_retire", 32'(retire_cnt), 32'd0);
        instr       = 8'h41;
        instr_valid = 1'b1;
        acc         = 0;
        last        = 0;
        for (int c = 0; c < 30 && acc < 4; c++) begin
            if (instr_ready === 1'b1) begin
                if (acc > 0) chk("accept_gap", 32'(c - last), 32'd3);
                last = c;
                exp_alu(8'(acc), 8'h01);
                acc++;
            end
            tick();
        end
        instr_valid = 1'b0;
        chk("stream_accepts", 32'(acc), 32'd4);
        wait_ready();
        chk("stream_retire", 32'(retire_cnt), 32'd4);

        // Same-register ADD doubles r0; r3 wraps 0 -> 0xFF -> 0x00
        exp_alu(8'h04, 8'h04);
        run(8'h00);
        outreg(2'd0, 8'h08);
        exp_alu(8'h00, 8'hFF);
        run(8'h7F);
        exp_alu(8'hFF, 8'h01);
        run(8'h7D);
        outreg(2'd3, 8'h00);
        chk("pre_halt_retire", 32'(retire_cnt), 32'd9);

        // HALT and ignored instructions afterwards
        issue(8'hC0);
        chk("halt_t1_halted", 32'(halted), 32'd0);
        tick();
        chk("halt_halted", 32'(halted),      32'd1);
        chk("halt_ready",  32'(instr_ready), 32'd0);
        chk("halt_retire", 32'(retire_cnt),  32'd10);
        for (int k = 0; k < 3; k++) begin
            instr       = 8'h45;
            instr_valid = 1'b1;
            tick();
            instr_valid = 1'b0;
            tick();
        end
        chk("halt_stay_halted", 32'(halted),      32'd1);
        chk("halt_stay_retire", 32'(retire_cnt),  32'd10);
        chk("halt_stay_ready",  32'(instr_ready), 32'd0);
        chk("halt_stay_outv",   32'(out_valid),   32'd0);

        do_reset();
        chk("unhalt_halted", 32'(halted),      32'd0);
        chk("unhalt_retire", 32'(retire_cnt),  32'd0);
        chk("unhalt_ready",  32'(instr_ready), 32'd1);
        outreg(2'd0, 8'h00);

        // Reset during EXEC of ADD r1+r1 -> r3 must suppress the write
        exp_alu(8'h00, 8'h01);
        run(8'h45);
        exp_alu(8'h01, 8'h01);
        issue(8'h17);
        tick();
        chk("exec_alu_op", 32'(alu_op), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("exec_rst_alu_op", 32'(alu_op),      32'd0);
        chk("exec_rst_ready",  32'(instr_ready), 32'd1);
        chk("exec_rst_retire", 32'(retire_cnt),  32'd0);
        chk("exec_rst_outv",   32'(out_valid),   32'd0);
        outreg(2'd3, 8'h00);
        outreg(2'd1, 8'h00);

        // Reset during an OUTP stall drops the pending output
        exp_alu(8'h00, 8'h01);
        run(8'h45);
        out_ready = 1'b0;
        outq.push_back(8'h01);
        issue(8'h90);
        tick();
        tick();
        tick();
        chk("outp_wait_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        outq.delete();
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        chk("outp_rst_valid",  32'(out_valid),   32'd0);
        chk("outp_rst_ready",  32'(instr_ready), 32'd1);
        chk("outp_rst_retire", 32'(retire_cnt),  32'd0);
        chk("outp_rst_halted", 32'(halted),      32'd0);
        outreg(2'd1, 8'h00);

        tick();
        tick();
        chk("aluq_drained", 32'(aluq.size()), 32'd0);
        chk("outq_drained", 32'(outq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
